// File: rtl/msp430_seq_pkg.sv
// Shared types and constants for the MSP430 instruction sequencer: state
// encoding, MAB select codes, instruction format codes and opcode values.
package msp430_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXT_SRC = 3'd2,
    EXT_DST = 3'd3,
    RD_SRC  = 3'd4,
    RD_DST  = 3'd5,
    EXEC    = 3'd6,
    WR_DST  = 3'd7
  } seq_state_t;

  localparam logic [1:0] MAB_PC   = 2'd0;
  localparam logic [1:0] MAB_SOUT = 2'd1;
  localparam logic [1:0] MAB_CALC = 2'd2;

  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_I    = 2'd1;
  localparam logic [1:0] FMT_II   = 2'd2;
  localparam logic [1:0] FMT_J    = 2'd3;

  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_BIT = 4'hB;

  // Format II keeps its source register in the low nibble, Format I in [11:8].
  function automatic logic [3:0] src_reg(input logic [15:0] instr);
    return (instr[15:14] == 2'b00) ? instr[3:0] : instr[11:8];
  endfunction

endpackage

// File: rtl/seq_mode_dec.sv
// Combinational addressing-mode decoder: from an instruction word, derives the
// format and which memory phases the sequencer has to walk through.
module seq_mode_dec
  import msp430_seq_pkg::*;
(
  input  logic [15:0] instr,
  output logic [1:0]  fmt,
  output logic        need_ext_src,
  output logic        need_rd_src,
  output logic        need_ext_dst,
  output logic        need_rd_dst,
  output logic        need_wr,
  output logic        cg,
  output logic        rw_ok,
  output logic        ainc_byte
);

  logic [3:0] op;
  logic [3:0] src;
  logic [1:0] as_mode;
  logic       ad;
  logic       has_src;
  logic       imm;
  logic       cmp_bit;

  always_comb begin
    op      = instr[15:12];
    src     = src_reg(instr);
    as_mode = instr[5:4];
    ad      = instr[7];

    fmt = FMT_NONE;
    if (instr[15:13] == 3'b001)
      fmt = FMT_J;
    else if (instr[15:12] == 4'b0001 && instr[11:10] == 2'b00)
      fmt = FMT_II;
    else if (instr[15:14] != 2'b00)
      fmt = FMT_I;

    has_src = (fmt == FMT_I) || (fmt == FMT_II);
    // R3 (any mode) and R2 in modes 1x supply constants without touching memory
    cg      = has_src && ((src == 4'd3) || (src == 4'd2 && as_mode[1]));
    imm     = (as_mode == 2'b11) && (src == 4'd0);
    cmp_bit = (op == OP_CMP) || (op == OP_BIT);

    need_ext_src = has_src && !cg && ((as_mode == 2'b01) || imm);
    need_rd_src  = has_src && !cg &&
                   ((as_mode == 2'b01) || (as_mode == 2'b10) ||
                    (as_mode == 2'b11 && src != 4'd0));
    need_ext_dst = (fmt == FMT_I) && ad;
    need_rd_dst  = need_ext_dst && (op != OP_MOV);
    need_wr      = ((fmt == FMT_I) && ad && !cmp_bit) ||
                   ((fmt == FMT_II) && (as_mode != 2'b00) && !cg);
    rw_ok        = ((fmt == FMT_I) && !ad && !cmp_bit) ||
                   ((fmt == FMT_II) && !need_wr);
    // SP always steps by a word so the stack stays aligned
    ainc_byte    = instr[6] && (src != 4'd1);
  end

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle MSP430 instruction sequencer with req/rdy memory handshake.
// Optional mem_rdy timeout is enabled by defining INSTR_SEQ_TMO_EN.
module instr_seq
  import msp430_seq_pkg::*;
#(
  parameter int AINC_W  = 2,
  parameter int TMO_CYC = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mdb_in,
  input  logic        mem_rdy,
  output logic [15:0] ir,
  output logic        mem_req,
  output logic [1:0]  mab_sel,
  output logic        pc_inc,
  output logic        ext_src_ld,
  output logic        ext_dst_ld,
  output logic        src_ld,
  output logic        dst_ld,
  output logic        ainc,
  output logic [1:0]  ainc_step,
  output logic        rw,
  output logic        mw,
  output logic        instr_done,
  output logic        tmo_err
);

  if (TMO_CYC < 1 || TMO_CYC > 15) begin : g_tmo_range
    $error("TMO_CYC must fit the 4-bit wait counter");
  end

  seq_state_t state, state_nxt;
  seq_state_t after_fetch, after_ext_src, after_rd_src, after_ext_dst;

  logic [15:0] dec_word;
  logic [1:0]  fmt;
  logic        need_ext_src, need_rd_src, need_ext_dst, need_rd_dst;
  logic        need_wr, cg, rw_ok, ainc_byte;
  logic        ir_ld;
  logic        tmo_hit;

  // The routing decision out of FETCH is made from the word being latched.
  assign dec_word = (state == FETCH) ? mdb_in : ir;

  seq_mode_dec u_dec (
    .instr        (dec_word),
    .fmt          (fmt),
    .need_ext_src (need_ext_src),
    .need_rd_src  (need_rd_src),
    .need_ext_dst (need_ext_dst),
    .need_rd_dst  (need_rd_dst),
    .need_wr      (need_wr),
    .cg           (cg),
    .rw_ok        (rw_ok),
    .ainc_byte    (ainc_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (ir_ld) ir <= mdb_in;
    end
  end

  always_comb begin
    after_ext_dst = need_rd_dst  ? RD_DST  : EXEC;
    after_rd_src  = need_ext_dst ? EXT_DST : after_ext_dst;
    after_ext_src = need_rd_src  ? RD_SRC  : after_rd_src;
    after_fetch   = need_ext_src ? EXT_SRC : after_ext_src;
  end

  always_comb begin
    state_nxt  = state;
    ir_ld      = 1'b0;
    mem_req    = 1'b0;
    mab_sel    = MAB_PC;
    pc_inc     = 1'b0;
    ext_src_ld = 1'b0;
    ext_dst_ld = 1'b0;
    src_ld     = 1'b0;
    dst_ld     = 1'b0;
    ainc       = 1'b0;
    ainc_step  = 2'd0;
    rw         = 1'b0;
    mw         = 1'b0;
    instr_done = 1'b0;

    case (state)
      IDLE: state_nxt = FETCH;

      FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_ld     = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = after_fetch;
        end
      end

      EXT_SRC: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ext_src_ld = 1'b1;
          pc_inc     = 1'b1;
          state_nxt  = after_ext_src;
        end
      end

      RD_SRC: begin
        mem_req = 1'b1;
        mab_sel = (ir[5:4] == 2'b01) ? MAB_CALC : MAB_SOUT;
        if (mem_rdy) begin
          src_ld    = 1'b1;
          ainc      = (ir[5:4] == 2'b11) && !cg;
          ainc_step = !ainc ? 2'd0 : (ainc_byte ? 2'd1 : 2'(AINC_W));
          state_nxt = after_rd_src;
        end
      end

      EXT_DST: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ext_dst_ld = 1'b1;
          pc_inc     = 1'b1;
          state_nxt  = after_ext_dst;
        end
      end

      RD_DST: begin
        mem_req = 1'b1;
        mab_sel = MAB_CALC;
        if (mem_rdy) begin
          dst_ld    = 1'b1;
          state_nxt = EXEC;
        end
      end

      EXEC: begin
        rw = rw_ok;
        if (need_wr) begin
          state_nxt = WR_DST;
        end else begin
          instr_done = 1'b1;
          state_nxt  = FETCH;
        end
      end

      WR_DST: begin
        mem_req = 1'b1;
        mw      = 1'b1;
        mab_sel = (fmt == FMT_II && ir[5]) ? MAB_SOUT : MAB_CALC;
        if (mem_rdy) begin
          instr_done = 1'b1;
          state_nxt  = FETCH;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // A stalled access is abandoned and the instruction is refetched.
    if (tmo_hit) begin
      state_nxt = FETCH;
      mab_sel   = MAB_PC;
    end
  end

`ifdef INSTR_SEQ_TMO_EN
  logic [3:0] wait_cnt;
  logic       tmo_q;

  assign tmo_hit = mem_req && !mem_rdy && (wait_cnt == 4'(TMO_CYC - 1));
  assign tmo_err = tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      if (tmo_hit) tmo_q <= 1'b1;
      if (!mem_req || mem_rdy || tmo_hit || state_nxt != state)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_seq.sv
// Scoreboard bench for instr_seq: the driver queues hand-computed per-cycle
// expectations, a monitor compares them against the DUT on the falling edge.
module tb_instr_seq;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_EXT_SRC = 3'd2;
  localparam logic [2:0] ST_EXT_DST = 3'd3;
  localparam logic [2:0] ST_RD_SRC  = 3'd4;
  localparam logic [2:0] ST_RD_DST  = 3'd5;
  localparam logic [2:0] ST_EXEC    = 3'd6;
  localparam logic [2:0] ST_WR_DST  = 3'd7;

  // Output vector: {tmo_err, mem_req, mab_sel[1:0], pc_inc, ext_src_ld,
  // ext_dst_ld, src_ld, dst_ld, ainc, ainc_step[1:0], rw, mw, instr_done}
  localparam logic [14:0] O_TMO  = 15'h4000;
  localparam logic [14:0] O_REQ  = 15'h2000;
  localparam logic [14:0] O_SOUT = 15'h0800;
  localparam logic [14:0] O_CALC = 15'h1000;
  localparam logic [14:0] O_PCI  = 15'h0400;
  localparam logic [14:0] O_XS   = 15'h0200;
  localparam logic [14:0] O_XD   = 15'h0100;
  localparam logic [14:0] O_SL   = 15'h0080;
  localparam logic [14:0] O_DL   = 15'h0040;
  localparam logic [14:0] O_AI   = 15'h0020;
  localparam logic [14:0] O_ST2  = 15'h0010;
  localparam logic [14:0] O_ST1  = 15'h0008;
  localparam logic [14:0] O_RW   = 15'h0004;
  localparam logic [14:0] O_MW   = 15'h0002;
  localparam logic [14:0] O_DN   = 15'h0001;

  typedef struct packed {
    logic [2:0]  st;
    logic [14:0] outs;
    logic [15:0] ir;
  } exp_t;

  logic        clk, rst_n, mem_rdy;
  logic [15:0] mdb_in, ir;
  logic        mem_req, pc_inc, ext_src_ld, ext_dst_ld, src_ld, dst_ld;
  logic        ainc, rw, mw, instr_done, tmo_err;
  logic [1:0]  mab_sel, ainc_step;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;
  logic        tmo_sticky;
  logic [15:0] cur_ir;

  instr_seq #(.AINC_W(2), .TMO_CYC(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mdb_in     (mdb_in),
    .mem_rdy    (mem_rdy),
    .ir         (ir),
    .mem_req    (mem_req),
    .mab_sel    (mab_sel),
    .pc_inc     (pc_inc),
    .ext_src_ld (ext_src_ld),
    .ext_dst_ld (ext_dst_ld),
    .src_ld     (src_ld),
    .dst_ld     (dst_ld),
    .ainc       (ainc),
    .ainc_step  (ainc_step),
    .rw         (rw),
    .mw         (mw),
    .instr_done (instr_done),
    .tmo_err    (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] outVec();
    return {tmo_err, mem_req, mab_sel, pc_inc, ext_src_ld, ext_dst_ld,
            src_ld, dst_ld, ainc, ainc_step, rw, mw, instr_done};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // One clock of stimulus; the bench tracks ir itself from accepted fetches.
  task automatic applyStimulus(input logic rdy, input logic [15:0] mdb,
                               input logic [2:0] st, input logic [14:0] outs);
    @(posedge clk);
    #1;
    mem_rdy = rdy;
    mdb_in  = mdb;
    sb.push_back('{st, outs | (tmo_sticky ? O_TMO : 15'h0), cur_ir});
    if (st == ST_FETCH && rdy) cur_ir = mdb;
  endtask

  task automatic releaseReset();
    rst_n      = 1'b1;
    mem_rdy    = 1'b1;
    mdb_in     = 16'h0;
    tmo_sticky = 1'b0;
    cur_ir     = 16'h0;
    sb.push_back('{ST_IDLE, 15'h0, 16'h0});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        cyc_n++;
        checkOutput($sformatf("cyc%0d state", cyc_n), 32'(dut.state), 32'(e.st));
        checkOutput($sformatf("cyc%0d outputs", cyc_n), 32'(outVec()), 32'(e.outs));
        checkOutput($sformatf("cyc%0d ir", cyc_n), 32'(ir), 32'(e.ir));
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; mem_rdy = 1'b0; mdb_in = 16'h0;
    tmo_sticky = 1'b0; cur_ir = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", 32'(dut.state), 32'(ST_IDLE));
    checkOutput("reset outputs", 32'(outVec()), 32'h0);
    checkOutput("reset ir", 32'(ir), 32'h0);
    releaseReset();

    // MOV R4,R5: register-register, 2 cycles
    applyStimulus(1, 16'h4405, ST_FETCH, O_REQ | O_PCI);
    applyStimulus(0, 16'h0000, ST_EXEC,  O_RW | O_DN);

    // ADD #0x1234,R6: immediate, 3 cycles
    applyStimulus(1, 16'h5036, ST_FETCH,   O_REQ | O_PCI);
    applyStimulus(1, 16'h1234, ST_EXT_SRC, O_REQ | O_PCI | O_XS);
    applyStimulus(1, 16'h0000, ST_EXEC,    O_RW | O_DN);

    // ADD 4(R5),2(R6): indexed to indexed, 7 cycles
    applyStimulus(1, 16'h5596, ST_FETCH,   O_REQ | O_PCI);
    applyStimulus(1, 16'h0004, ST_EXT_SRC, O_REQ | O_PCI | O_XS);
    applyStimulus(1, 16'hABCD, ST_RD_SRC,  O_REQ | O_CALC | O_SL);
    applyStimulus(1, 16'h0002, ST_EXT_DST, O_REQ | O_PCI | O_XD);
    applyStimulus(1, 16'h1111, ST_RD_DST,  O_REQ | O_CALC | O_DL);
    applyStimulus(1, 16'h0000, ST_EXEC,    15'h0);
    applyStimulus(1, 16'h0000, ST_WR_DST,  O_REQ | O_CALC | O_MW | O_DN);

    // MOV @R7+,R8 word and byte autoincrement
    applyStimulus(1, 16'h4738, ST_FETCH,  O_REQ | O_PCI);
    applyStimulus(1, 16'hBEEF, ST_RD_SRC, O_REQ | O_SOUT | O_SL | O_AI | O_ST2);
    applyStimulus(1, 16'h0000, ST_EXEC,   O_RW | O_DN);
    applyStimulus(1, 16'h4778, ST_FETCH,  O_REQ | O_PCI);
    applyStimulus(1, 16'hBEEF, ST_RD_SRC, O_REQ | O_SOUT | O_SL | O_AI | O_ST1);
    applyStimulus(1, 16'h0000, ST_EXEC,   O_RW | O_DN);

    // Fetch stalled 3 cycles, then CMP R4,R5 (no write), rdy ignored in EXEC
    for (int i = 0; i < 3; i++) applyStimulus(0, 16'hFFFF, ST_FETCH, O_REQ);
    applyStimulus(1, 16'h9405, ST_FETCH, O_REQ | O_PCI);
    applyStimulus(0, 16'h0000, ST_EXEC,  O_DN);

    // ADD #1,R5 via constant generator
    applyStimulus(1, 16'h5315, ST_FETCH, O_REQ | O_PCI);
    applyStimulus(1, 16'h0000, ST_EXEC,  O_RW | O_DN);

    // MOV R4,2(R6): destination extension without destination read
    applyStimulus(1, 16'h4486, ST_FETCH,   O_REQ | O_PCI);
    applyStimulus(1, 16'h0002, ST_EXT_DST, O_REQ | O_PCI | O_XD);
    applyStimulus(1, 16'h0000, ST_EXEC,    15'h0);
    applyStimulus(1, 16'h0000, ST_WR_DST,  O_REQ | O_CALC | O_MW | O_DN);

    // JMP, then two unused opcodes: 2-cycle no-ops
    applyStimulus(1, 16'h3C00, ST_FETCH, O_REQ | O_PCI);
    applyStimulus(1, 16'h0000, ST_EXEC,  O_DN);
    applyStimulus(1, 16'h0000, ST_FETCH, O_REQ | O_PCI);
    applyStimulus(1, 16'h0000, ST_EXEC,  O_DN);
    applyStimulus(1, 16'h1400, ST_FETCH, O_REQ | O_PCI);
    applyStimulus(1, 16'h0000, ST_EXEC,  O_DN);

`ifdef INSTR_SEQ_TMO_EN
    for (int i = 0; i < 15; i++) applyStimulus(0, 16'hFFFF, ST_FETCH, O_REQ);
    tmo_sticky = 1'b1;
    applyStimulus(0, 16'hFFFF, ST_FETCH, O_REQ);
    applyStimulus(1, 16'h4405, ST_FETCH, O_REQ | O_PCI);
    applyStimulus(1, 16'h0000, ST_EXEC,  O_RW | O_DN);
`endif

    // Reset while WR_DST is waiting on memory
    applyStimulus(1, 16'h5596, ST_FETCH,   O_REQ | O_PCI);
    applyStimulus(1, 16'h0004, ST_EXT_SRC, O_REQ | O_PCI | O_XS);
    applyStimulus(1, 16'hABCD, ST_RD_SRC,  O_REQ | O_CALC | O_SL);
    applyStimulus(1, 16'h0002, ST_EXT_DST, O_REQ | O_PCI | O_XD);
    applyStimulus(1, 16'h1111, ST_RD_DST,  O_REQ | O_CALC | O_DL);
    applyStimulus(0, 16'h0000, ST_EXEC,    15'h0);
    applyStimulus(0, 16'h0000, ST_WR_DST,  O_REQ | O_CALC | O_MW);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset mw", 32'(mw), 32'h0);
    checkOutput("async reset mem_req", 32'(mem_req), 32'h0);
    checkOutput("async reset state", 32'(dut.state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    releaseReset();
    applyStimulus(0, 16'h0000, ST_FETCH, O_REQ);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
